// File: rtl/vote_frame_assembler_if.sv
// Vote stream in / assembled frame out bundle for vote_frame_assembler.
// VOTE_MAJ_CHECK_EN adds the out_maj golden-majority signal.
interface vote_frame_assembler_if #(
  parameter int unsigned N  = 17,
  parameter int unsigned CW = $clog2(N + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic          in_bit;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_x;
  logic [CW-1:0] out_count;
  logic          frame_err;
`ifdef VOTE_MAJ_CHECK_EN
  logic          out_maj;

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_x, out_count, frame_err, out_maj
  );
  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_x, out_count, frame_err, out_maj
  );
`else
  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_x, out_count, frame_err
  );
  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_x, out_count, frame_err
  );
`endif
endinterface

// File: rtl/vote_frame_assembler.sv
// Serial vote collector feeding the N-input majority gate: accepts one vote
// bit per beat, assembles an N-bit vector plus popcount and holds it until
// the consumer takes it. Optional macro VOTE_MAJ_CHECK_EN adds out_maj.
module vote_frame_assembler #(
  parameter int unsigned N  = 17,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  vote_frame_assembler_if.slave bus
);

  localparam int unsigned IW = $clog2(N);
`ifdef VOTE_MAJ_CHECK_EN
  localparam int unsigned THRESH = (N + 1) / 2;
`endif

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_x_q, out_x_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          frame_err_q, frame_err_d;
`ifdef VOTE_MAJ_CHECK_EN
  logic          out_maj_q, out_maj_d;
`endif

  logic          in_ready_c;
  logic          accept_c;
  logic [N-1:0]  vec_nxt_c;
  logic [CW-1:0] cnt_nxt_c;

  // Next-state: accept votes, complete/retire frames, flag framing errors.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_count_d = out_count_q;
    frame_err_d = 1'b0;
`ifdef VOTE_MAJ_CHECK_EN
    out_maj_d   = out_maj_q;
`endif

    // While a frame is held, votes flow only when the consumer retires it.
    in_ready_c = ~rst & ((state_q == COLLECT) | bus.out_ready);
    accept_c   = bus.in_valid & in_ready_c;

    vec_nxt_c          = vec_q;
    vec_nxt_c[idx_q]   = bus.in_bit;
    cnt_nxt_c          = cnt_q + CW'(bus.in_bit);

    if ((state_q == FULL) && bus.out_ready) begin
      state_d     = COLLECT;
      out_valid_d = 1'b0;
    end

    if (accept_c) begin
      if (idx_q == IW'(N - 1)) begin
        state_d     = FULL;
        out_valid_d = 1'b1;
        out_x_d     = vec_nxt_c;
        out_count_d = cnt_nxt_c;
        frame_err_d = ~bus.in_last;
`ifdef VOTE_MAJ_CHECK_EN
        out_maj_d   = (cnt_nxt_c >= CW'(THRESH));
`endif
        idx_d       = '0;
        vec_d       = '0;
        cnt_d       = '0;
      end else if (bus.in_last) begin
        // Early last: drop the partial frame.
        frame_err_d = 1'b1;
        idx_d       = '0;
        vec_d       = '0;
        cnt_d       = '0;
      end else begin
        idx_d       = idx_q + IW'(1);
        vec_d       = vec_nxt_c;
        cnt_d       = cnt_nxt_c;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      vec_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_count_q <= '0;
      frame_err_q <= 1'b0;
`ifdef VOTE_MAJ_CHECK_EN
      out_maj_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_count_q <= out_count_d;
      frame_err_q <= frame_err_d;
`ifdef VOTE_MAJ_CHECK_EN
      out_maj_q   <= out_maj_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_count = out_count_q;
  assign bus.frame_err = frame_err_q;
`ifdef VOTE_MAJ_CHECK_EN
  assign bus.out_maj   = out_maj_q;
`endif

endmodule

// File: tb/tb_vote_frame_assembler.sv
// Self-checking bench for vote_frame_assembler: directed scenarios plus
// randomized traffic against a queue-based frame model.
module tb_vote_frame_assembler;
  localparam int unsigned N      = 17;
  localparam int unsigned CW     = $clog2(N + 1);
  localparam int unsigned THRESH = (N + 1) / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vote_frame_assembler_if #(.N(N), .CW(CW)) bus ();
  vote_frame_assembler #(.N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  // Reference model: votes of the frame in progress, and the held frame.
  bit          cur_q[$];
  bit          held = 1'b0;
  logic [N-1:0] exp_x = '0;
  int unsigned exp_cnt = 0;
  bit          exp_err = 1'b0;

  int unsigned cyc = 0;
  bit          prev_v = 1'b0;
  int unsigned rise_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive, check in_ready, advance model, check outputs.
  task automatic step(input bit r, input bit v, input bit b, input bit l, input bit o);
    bit rdy, acc;
    @(negedge clk);
    rst = r; bus.in_valid = v; bus.in_bit = b; bus.in_last = l; bus.out_ready = o;
    #1;
    rdy = !r && (!held || o);
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
    acc = v && rdy;
    exp_err = 1'b0;
    if (r) begin
      cur_q.delete();
      held = 1'b0; exp_x = '0; exp_cnt = 0;
    end else begin
      if (held && o) held = 1'b0;
      if (acc) begin
        cur_q.push_back(b);
        if (cur_q.size() == N) begin
          held = 1'b1; exp_cnt = 0;
          for (int i = 0; i < int'(N); i++) begin
            exp_x[i] = cur_q[i];
            exp_cnt += int'(cur_q[i]);
          end
          exp_err = !l;
          cur_q.delete();
        end else if (l) begin
          exp_err = 1'b1;
          cur_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("out_valid", 64'(bus.out_valid), 64'(held));
    check("frame_err", 64'(bus.frame_err), 64'(exp_err));
    if (held || r) begin
      check("out_x", 64'(bus.out_x), 64'(exp_x));
      check("out_count", 64'(bus.out_count), 64'(exp_cnt));
`ifdef VOTE_MAJ_CHECK_EN
      check("out_maj", 64'(bus.out_maj), 64'(exp_cnt >= THRESH));
`endif
    end
    if (bus.out_valid && !prev_v) rise_q.push_back(cyc);
    prev_v = bus.out_valid;
  endtask

  // Send n beats of bits (LSB first); in_last on beat index last_at (-1: none).
  task automatic send_beats(input logic [N-1:0] bits, input int n, input int last_at, input bit o);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, bits[i], (i == last_at), o);
  endtask

  initial begin
    logic [N-1:0] rb;
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    // Reset held with in_valid asserted.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single all-ones frame, then majority boundary frames.
    send_beats(17'h1FFFF, N, N - 1, 1'b1);
    check("allones_x", 64'(bus.out_x), 64'h1FFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beats(17'h001FF, N, N - 1, 1'b1);
    check("thresh_cnt", 64'(bus.out_count), 64'd9);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beats(17'h000FF, N, N - 1, 1'b1);
    check("below_cnt", 64'(bus.out_count), 64'd8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: hold frame 5 cycles, then retire while accepting vote 0.
    send_beats(17'h0A5A5, N, N - 1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_hold_x", 64'(bus.out_x), 64'h0A5A5);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    send_beats(17'h00000, N - 1, N - 2, 1'b1);
    check("bp_bit0_x", 64'(bus.out_x), 64'h00001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Early last on beat 5, then a clean frame; then missing last.
    send_beats(17'h0001F, 5, 4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beats(17'h15555, N, N - 1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beats(17'h0F0F0, N, -1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back frames: one output per N cycles.
    rise_q.delete();
    for (int f = 0; f < 3; f++) begin
      rb = N'($urandom);
      send_beats(rb, N, N - 1, 1'b1);
    end
    check("b2b_frames", 64'(rise_q.size()), 64'd3);
    if (rise_q.size() == 3) begin
      check("b2b_gap0", 64'(rise_q[1] - rise_q[0]), 64'(N));
      check("b2b_gap1", 64'(rise_q[2] - rise_q[1]), 64'(N));
    end
    // Reset mid frame 4, then a fresh frame starting at idx 0.
    send_beats(17'h003FF, 10, -1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    send_beats(17'h10001, N, N - 1, 1'b1);
    check("post_rst_x", 64'(bus.out_x), 64'h10001);

    // Randomized traffic with occasional framing faults and resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, v, b, l, o;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 3) != 0);
      b = 1'($urandom);
      if (cur_q.size() == N - 1) l = ($urandom_range(0, 9) != 0);
      else                       l = ($urandom_range(0, 39) == 0);
      step(r, v, b, l, o);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/vote_frame_assembler.md
Name: vote_frame_assembler

Overview:
- Upstream feeder for the 17-input majority gate.
- Collects votes serially, one bit per accepted beat, over a valid/ready stream and assembles an N-bit vote vector.
- Presents the vector with a running popcount to the downstream majority stage: out_x[i] drives x<i> of the gate.
- Holds each frame until the consumer accepts it (backpressure).

Parameters:
- N, 17, vote count per frame; odd, legal range 3..63.
- CW, $clog2(N+1), width of the popcount output (5 for N=17).
- THRESH, (N+1)/2, majority threshold (9 for N=17); used only by the optional feature.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  vote beat valid.
- in_ready  output  1  assembler can accept a vote this cycle.
- in_bit  input  1  vote value.
- in_last  input  1  producer marks final vote of a frame.
- out_valid  output  1  complete frame held on out_x.
- out_ready  input  1  downstream accepts the frame.
- out_x  output  N  assembled vote vector; bit i = i-th accepted vote (LSB first).
- out_count  output  CW  number of ones in out_x.
- frame_err  output  1  one-cycle pulse on framing error.

Behaviour:
- Reset: every output 0 (in_ready=0 during rst), idx=0, state=COLLECT. In the cycle after rst deasserts, in_ready=1. Reset mid-frame discards partial votes and any held frame.
- State COLLECT: in_ready=1.
  - Accept = in_valid & in_ready.
  - On accept: vec[idx] <= in_bit; cnt <= cnt + in_bit; idx <= idx + 1.
- Completion: accepting with idx==N-1 moves to state FULL.
  - Next cycle: out_valid=1, out_x=vec, out_count=cnt. Latency is 1 cycle from the last accept.
  - idx and the accumulators clear for the next frame.
- State FULL: out_x and out_count stay stable while out_valid & !out_ready.
  - in_ready = out_ready, combinational pass-through for full throughput.
  - If out_valid & out_ready: frame retires; out_valid drops next cycle unless a new frame completes.
  - Any vote accepted in that same cycle is stored as vote 0 of the next frame.
- Throughput: one frame per N cycles sustained when out_ready is held at 1. No bubble is required between frames.
- Framing rules:
  - in_last=1 accepted with idx<N-1 (early last): the partial frame is discarded, idx=0, cnt=0, frame_err=1 for exactly one cycle. No output frame is produced.
  - in_last=0 accepted with idx==N-1: the frame still completes normally and frame_err pulses one cycle in the same cycle out_valid rises.
  - in_last=1 at idx==N-1: normal completion, no error.
- Wrap: idx is never allowed to exceed N-1. The counter returns to 0 on completion or error.
- Width: cnt is CW bits and never overflows, since the maximum is N.
- in_bit and in_last are ignored whenever accept=0.
- Simultaneous rst with any handshake: rst wins.

Optional Feature:
- Macro: VOTE_MAJ_CHECK_EN.
- When defined: adds output port out_maj (1 bit, registered, reset 0). It is valid whenever out_valid=1, equals (out_count >= THRESH), and is updated in the same cycle as out_x. It serves as an in-line golden reference for comparing against the downstream gate's y0.
- When undefined: the port and its logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> all outputs 0; in_ready=1 in the first cycle after release.
- Single frame: 17 beats of in_bit=1 (in_last on beat 17), out_ready=1 -> out_valid high 1 cycle after beat 17, out_x=17'h1FFFF, out_count=17, out_maj=1.
- Majority boundary: votes 0..8 = 1, 9..16 = 0 -> out_x=17'h001FF, out_count=9, out_maj=1. Then votes 0..7 = 1 -> out_x=17'h000FF, out_count=8, out_maj=0.
- Backpressure: complete a frame with out_ready=0 for 5 cycles -> out_x stable, in_ready=0. Then raise out_ready together with in_valid -> the accepted bit lands in bit 0 of the next frame.
- Framing errors:
  - in_last on beat 5 -> frame_err pulses 1 cycle, no out_valid; the next 17 beats form a clean frame.
  - Missing in_last on beat 17 -> the frame is delivered and frame_err pulses with out_valid.
- Back-to-back with reset mid-frame: stream 3 frames with out_ready=1 -> one frame per 17 cycles. Assert rst after beat 10 of frame 4 -> no output for frame 4; the next frame starts at idx 0.
